// File: rtl/run_detect_pkg.sv
// Shared definitions for the run detector: detection mode encoding and
// the width of the run-count state / RUN output.
package run_detect_pkg;

    localparam int unsigned RUN_W = 4;

    typedef enum logic {
        OVERLAP    = 1'b0,
        NONOVERLAP = 1'b1
    } mode_e;

endpackage

// File: rtl/run_detect_moore_sat_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
// Clear wins over a coincident increment; the count sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         CK,
    input  logic         R,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear first, then saturating increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, asynchronously cleared by R.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_detect_moore.sv
// Moore run detector: the state is the length of the current run of bits
// equal to POL, capped at RUN_LEN. OUT flags a complete run, HITS counts
// detections (saturating) and can be cleared independently of EN.
module run_detect_moore
    import run_detect_pkg::*;
#(
    parameter int unsigned RUN_LEN = 2,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CK,
    input  logic             R,
    input  logic             EN,
    input  logic             IN,
    input  logic             POL,
    input  logic             MODE,
    input  logic             CLR,
    output logic             OUT,
    output logic [RUN_W-1:0] RUN,
    output logic [CNT_W-1:0] HITS
);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    logic [RUN_W-1:0] cnt_q;
    logic [RUN_W-1:0] cnt_d;
    logic             det;
    mode_e            mode_s;

    assign mode_s = mode_e'(MODE);

    // Next run count and detection strobe; out-of-range counts fall back to 0
    // on any edge so a corrupted state cannot persist while EN is low.
    always_comb begin
        cnt_d = cnt_q;
        det   = 1'b0;
        if (cnt_q > RUN_MAX) begin
            cnt_d = '0;
        end else if (EN) begin
            if (IN != POL) begin
                cnt_d = '0;
            end else if (cnt_q < RUN_MAX) begin
                cnt_d = cnt_q + RUN_W'(1);
            end else if (mode_s == OVERLAP) begin
                cnt_d = RUN_MAX;
            end else begin
                cnt_d = RUN_W'(1);
            end
            det = (cnt_d == RUN_MAX);
        end
    end

    // Run-count state register.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Moore outputs decoded from state only.
    always_comb begin
        OUT = (cnt_q == RUN_MAX);
        RUN = cnt_q;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_hits (
        .CK     (CK),
        .R      (R),
        .inc    (det),
        .clr    (CLR),
        .count_o(HITS)
    );

endmodule

// File: tb/tb_run_detect_moore.sv
// Self-checking bench for run_detect_moore: three instances with different
// RUN_LEN / CNT_W share one stimulus stream and are compared every cycle
// against an integer reference model, plus directed scenario checks.
module tb_run_detect_moore;

    logic CK = 1'b0;
    logic R, EN, IN, POL, MODE, CLR;

    logic       o0, o1, o2;
    logic [3:0] r0, r1, r2;
    logic [7:0] h0, h1;
    logic [1:0] h2;

    always #5 CK = ~CK;

    run_detect_moore #(.RUN_LEN(2), .CNT_W(8)) u_dut0 (
        .CK(CK), .R(R), .EN(EN), .IN(IN), .POL(POL), .MODE(MODE), .CLR(CLR),
        .OUT(o0), .RUN(r0), .HITS(h0)
    );
    run_detect_moore #(.RUN_LEN(3), .CNT_W(8)) u_dut1 (
        .CK(CK), .R(R), .EN(EN), .IN(IN), .POL(POL), .MODE(MODE), .CLR(CLR),
        .OUT(o1), .RUN(r1), .HITS(h1)
    );
    run_detect_moore #(.RUN_LEN(2), .CNT_W(2)) u_dut2 (
        .CK(CK), .R(R), .EN(EN), .IN(IN), .POL(POL), .MODE(MODE), .CLR(CLR),
        .OUT(o2), .RUN(r2), .HITS(h2)
    );

    int RL[3]   = '{2, 3, 2};
    int HMAX[3] = '{255, 255, 3};
    int m_cnt[3];
    int m_hits[3];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: run length of matching bits, capped or restarted at RL.
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int nxt;
            bit det;
            nxt = m_cnt[k];
            det = 1'b0;
            if (EN) begin
                if (IN != POL)        nxt = 0;
                else if (nxt < RL[k]) nxt = nxt + 1;
                else if (MODE == 0)   nxt = RL[k];
                else                  nxt = 1;
                det = (nxt == RL[k]);
            end
            if (CLR)      m_hits[k] = 0;
            else if (det) m_hits[k] = (m_hits[k] + 1 > HMAX[k]) ? HMAX[k] : m_hits[k] + 1;
            m_cnt[k] = nxt;
        end
    endtask

    task automatic compare_all();
        check("out0", int'(o0), int'(m_cnt[0] == RL[0]));
        check("run0", int'(r0), m_cnt[0]);
        check("hits0", int'(h0), m_hits[0]);
        check("out1", int'(o1), int'(m_cnt[1] == RL[1]));
        check("run1", int'(r1), m_cnt[1]);
        check("hits1", int'(h1), m_hits[1]);
        check("out2", int'(o2), int'(m_cnt[2] == RL[2]));
        check("run2", int'(r2), m_cnt[2]);
        check("hits2", int'(h2), m_hits[2]);
    endtask

    // Called just after a falling edge: apply inputs, take one edge, check.
    task automatic step(input logic en, input logic in);
        EN = en;
        IN = in;
        @(posedge CK);
        model_edge();
        @(negedge CK);
        compare_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear with no edge.
    task automatic do_reset();
        R = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k]  = 0;
            m_hits[k] = 0;
        end
        compare_all();
        #1;
        R = 1'b0;
    endtask

    bit exp31[6] = '{0, 0, 1, 1, 1, 0};
    bit exp32[6] = '{0, 0, 1, 0, 1, 0};
    bit in31[6]  = '{0, 1, 1, 1, 1, 0};
    bit in33[6]  = '{0, 0, 1, 0, 0, 0};
    int run33[6] = '{1, 2, 0, 1, 2, 3};

    initial begin
        R = 1'b0; EN = 1'b0; IN = 1'b0; POL = 1'b1; MODE = 1'b0; CLR = 1'b0;
        @(negedge CK);
        do_reset();

        // Overlapping, RUN_LEN=2
        for (int i = 0; i < 6; i++) begin
            step(1'b1, in31[i]);
            check("s31_out", int'(o0), int'(exp31[i]));
        end
        check("s31_hits", int'(h0), 3);

        // Non-overlapping, same stream
        do_reset();
        MODE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, in31[i]);
            check("s32_out", int'(o0), int'(exp32[i]));
        end
        check("s32_hits", int'(h0), 2);

        // Counting zeros, RUN_LEN=3
        do_reset();
        MODE = 1'b0;
        POL  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, in33[i]);
            check("s33_run", int'(r1), run33[i]);
            check("s33_out", int'(o1), int'(i == 5));
        end

        // Enable gap inside a run, RUN_LEN=3
        do_reset();
        POL = 1'b1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("s34_gap_run", int'(r1), 2);
        step(1'b1, 1'b1);
        check("s34_out", int'(o1), 1);

        // Saturation at CNT_W=2, then clear coincident with a detection
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        check("s35_sat", int'(h2), 3);
        CLR = 1'b1;
        step(1'b1, 1'b1);
        CLR = 1'b0;
        check("s35_clr", int'(h2), 0);
        // Clear while disabled
        step(1'b1, 1'b1);
        CLR = 1'b1;
        step(1'b0, 1'b0);
        CLR = 1'b0;
        check("s35_clr_dis", int'(h0), 0);

        // Mid-run reset then restart
        do_reset();
        step(1'b1, 1'b1);
        check("s36_pre", int'(r0), 1);
        do_reset();
        check("s36_run", int'(r0), 0);
        check("s36_hits", int'(h0), 0);
        step(1'b1, 1'b1);
        check("s36_restart", int'(r0), 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 31) == 0) POL  = 1'($urandom);
            if ($urandom_range(0, 31) == 0) MODE = 1'($urandom);
            CLR = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            step(1'($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 3) != 0) ? POL : ~POL);
        end
        CLR = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/run_detect_moore.md
RUN_DETECT_MOORE -- requirements
Module: run_detect_moore

Interface
REQ-001 The block SHALL have parameter RUN_LEN, default 2, giving the number of consecutive matching bits that counts as a detection; legal range is 2..15.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the detection counter; legal range is 1..16.
REQ-003 The block SHALL have port CK, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port R, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port EN, input, 1 bit: sample enable; while low, all state holds.
REQ-006 The block SHALL have port IN, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port POL, input, 1 bit: the bit value being counted (1 counts ones, 0 counts zeros).
REQ-008 The block SHALL have port MODE, input, 1 bit: 0 selects overlapping detection, 1 selects non-overlapping detection.
REQ-009 The block SHALL have port CLR, input, 1 bit: synchronous clear of HITS.
REQ-010 The block SHALL have port OUT, output, 1 bit: Moore detect flag.
REQ-011 The block SHALL have port RUN, output, 4 bits: current run count (0..RUN_LEN).
REQ-012 The block SHALL have port HITS, output, CNT_W bits: saturating count of detections.

Function
REQ-013 The FSM SHALL be a Moore machine whose state is the run count cnt in 0..RUN_LEN; OUT SHALL equal (cnt == RUN_LEN) and RUN SHALL equal cnt, both decoded from state only.
REQ-014 On a rising CK edge with EN=1 and IN!=POL, cnt SHALL go to 0.
REQ-015 On a rising CK edge with EN=1, IN==POL and cnt<RUN_LEN, cnt SHALL increment by 1.
REQ-016 On a rising CK edge with EN=1, IN==POL, cnt==RUN_LEN and MODE=0, cnt SHALL stay at RUN_LEN, so OUT stays high.
REQ-017 On a rising CK edge with EN=1, IN==POL, cnt==RUN_LEN and MODE=1, cnt SHALL go to 1, because the current bit starts a new run.
REQ-018 OUT SHALL assert in the cycle after the edge that samples the RUN_LEN-th consecutive matching bit, giving one clock of latency.
REQ-019 A detection event SHALL be every enabled edge whose next cnt equals RUN_LEN.
REQ-020 On each detection event, HITS SHALL increment by 1 and saturate at 2^CNT_W-1 without wrap.
REQ-021 CLR=1 at a rising edge SHALL set HITS to 0, regardless of EN; CLR SHALL take priority over a simultaneous detection increment.
REQ-022 With EN=0, cnt and HITS SHALL hold and IN SHALL be ignored, except for the CLR action.
REQ-023 Changes on MODE or POL SHALL take effect at the next enabled edge; existing cnt SHALL NOT be reinterpreted.
REQ-024 Unreachable state encodings (cnt > RUN_LEN) SHALL recover to 0 on the next edge.

Reset
REQ-025 Asserting R SHALL immediately, without a clock edge, force cnt=0, OUT=0, RUN=0 and HITS=0.
REQ-026 Reset asserted mid-run SHALL discard the partial run; after R deasserts, counting SHALL restart from 0 at the first enabled edge.
REQ-027 The reset sensitivity SHALL be (posedge CK or posedge R) only.

Structure
REQ-028 A shared package run_detect_pkg SHALL hold the MODE encodings (OVERLAP=0, NONOVERLAP=1) and the RUN/cnt width constant of 4 bits.
REQ-029 The HITS logic SHALL be a sub-module sat_counter, with width parameter, inputs inc and clr, and async reset R; it SHALL be instantiated once.
REQ-030 Next-state/output decode SHALL be a separate combinational block from the state register.

Verification
REQ-031 Scenario: RUN_LEN=2, POL=1, MODE=0, IN = 0,1,1,1,1,0 -> OUT high for 3 cycles starting after the 3rd bit; HITS=3.
REQ-032 Scenario: same stream with MODE=1 -> OUT pulses after the 3rd and 5th bits; HITS=2.
REQ-033 Scenario: RUN_LEN=3, POL=0, IN = 0,0,1,0,0,0 -> OUT low until after the 6th bit, then high; RUN sequence 1,2,0,1,2,3.
REQ-034 Scenario: EN low for 2 cycles in the middle of run 1,1,(EN=0 x2),1 with RUN_LEN=3 -> the run survives the gap; OUT high after the 3rd enabled 1.
REQ-035 Scenario: CNT_W=2, 5 detections -> HITS saturates at 3; CLR coincident with a detection -> HITS=0.
REQ-036 Scenario: assert R between edges while RUN=1 -> RUN, OUT and HITS become 0 immediately; the next stream restarts counting from 0.
